// File: rtl/pipe_sum.sv
// Pipelined add/subtract: operands are consumed one CHUNK-bit slice per stage,
// with the carry travelling alongside the data and valid/ready backpressure per stage.
module pipe_sum #(
    parameter int BUS_WIDTH = 32,
    parameter int STAGES    = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [BUS_WIDTH-1:0] sum_in1,
    input  logic [BUS_WIDTH-1:0] sum_in2,
    input  logic                 sum_in_sub,
    input  logic                 sum_in_en,
    output logic                 sum_in_ready,
    output logic [BUS_WIDTH-1:0] sum_out,
    output logic                 sum_out_en,
    input  logic                 sum_out_ready,
    output logic                 carry_bit_out,
    output logic                 overflow_out
);

    localparam int CHUNK = BUS_WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (STAGES < 1 || STAGES > BUS_WIDTH || (BUS_WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_sum: STAGES must be in 1..BUS_WIDTH and divide BUS_WIDTH");
    end

    // Handshake: a stage moves data forward on a rising edge when its ready is 1.
    // ready_k = !valid_k || ready_{k+1}, and the last stage uses sum_out_ready,
    // so an empty slot anywhere lets everything upstream of it advance.
    logic [STAGES-1:0] rdy;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be summed when entering stage k (low slice is consumed here).
        localparam int REM = BUS_WIDTH - k * CHUNK;

        logic [REM-1:0]           a_src;
        logic [REM-1:0]           b_src;
        logic                     c_src;
        logic                     v_src;
        logic [CHUNK:0]           slice_sum;
        logic [(k+1)*CHUNK-1:0]   s_d;
        logic [(k+1)*CHUNK-1:0]   s_q;
        logic                     c_q;
        logic                     v_q;

        if (k == 0) begin : g_in
            assign a_src = sum_in1;
            assign b_src = sum_in_sub ? ~sum_in2 : sum_in2;
            assign c_src = sum_in_sub;
            assign v_src = sum_in_en;
            assign s_d   = slice_sum[CHUNK-1:0];
        end else begin : g_chain
            assign a_src = g_stage[k-1].g_ops.a_q;
            assign b_src = g_stage[k-1].g_ops.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_d   = {slice_sum[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign slice_sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, c_src};

        if (k == LAST) begin : g_rdy_last
            assign rdy[k] = !v_q || sum_out_ready;
        end else begin : g_rdy_mid
            assign rdy[k] = !v_q || rdy[k+1];
        end

        // Data only moves with a real transaction; bubbles leave the old contents in place.
        always_ff @(posedge clk or negedge arst) begin
            if (!arst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy[k]) begin
                v_q <= v_src;
                if (v_src) begin
                    c_q <= slice_sum[CHUNK];
                    s_q <= s_d;
                end
            end
        end

        if (k < LAST) begin : g_ops
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rdy[k] && v_src) begin
                    a_q <= a_src[REM-1:CHUNK];
                    b_q <= b_src[REM-1:CHUNK];
                end
            end
        end else begin : g_out
            logic ovf_d;
            logic ovf_q;

            // The top slice carries the operand MSBs, so overflow is decided here.
            assign ovf_d = (a_src[REM-1] == b_src[REM-1]) && (slice_sum[CHUNK-1] != a_src[REM-1]);

            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    ovf_q <= 1'b0;
                end else if (rdy[k] && v_src) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign sum_in_ready  = rdy[0];
    assign sum_out_en    = g_stage[LAST].v_q;
    assign sum_out       = g_stage[LAST].s_q;
    assign carry_bit_out = g_stage[LAST].c_q;
    assign overflow_out  = g_stage[LAST].g_out.ovf_q;

endmodule

// File: tb/tb_pipe_sum.sv
// Directed bench for pipe_sum: three instances (STAGES 4, 1, 32) with hand-computed
// expectations, backpressure, bubble collapse and mid-stream reset.
module tb_pipe_sum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst;
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] out [3];
    logic        sub [3];
    logic        en [3];
    logic        in_rdy [3];
    logic        out_en [3];
    logic        out_rdy [3];
    logic        cy [3];
    logic        ov [3];

    int total = 0;
    int bad   = 0;

    pipe_sum #(.BUS_WIDTH(32), .STAGES(4)) u_s4 (
        .clk(clk), .arst(arst), .sum_in1(a[0]), .sum_in2(b[0]), .sum_in_sub(sub[0]),
        .sum_in_en(en[0]), .sum_in_ready(in_rdy[0]), .sum_out(out[0]), .sum_out_en(out_en[0]),
        .sum_out_ready(out_rdy[0]), .carry_bit_out(cy[0]), .overflow_out(ov[0])
    );

    pipe_sum #(.BUS_WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .arst(arst), .sum_in1(a[1]), .sum_in2(b[1]), .sum_in_sub(sub[1]),
        .sum_in_en(en[1]), .sum_in_ready(in_rdy[1]), .sum_out(out[1]), .sum_out_en(out_en[1]),
        .sum_out_ready(out_rdy[1]), .carry_bit_out(cy[1]), .overflow_out(ov[1])
    );

    pipe_sum #(.BUS_WIDTH(32), .STAGES(32)) u_s32 (
        .clk(clk), .arst(arst), .sum_in1(a[2]), .sum_in2(b[2]), .sum_in_sub(sub[2]),
        .sum_in_en(en[2]), .sum_in_ready(in_rdy[2]), .sum_out(out[2]), .sum_out_en(out_en[2]),
        .sum_out_ready(out_rdy[2]), .carry_bit_out(cy[2]), .overflow_out(ov[2])
    );

    function automatic int stg(input int d);
        case (d)
            0: return 4;
            1: return 1;
            default: return 32;
        endcase
    endfunction

    // Driver: called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, output bit ok);
        a[d] = av; b[d] = bv; sub[d] = sv; en[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1 ok = in_rdy[d];
            @(posedge clk);
            @(negedge clk);
        end
        en[d] = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout dut%0d: got no accept, expected accept within 200 cycles", d);
        end
    endtask

    // cyc counts rising edges from the accepting edge (inclusive) to sum_out_en.
    task automatic wait_out(input int d, output int cyc);
        cyc = 1;
        while (out_en[d] !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (out_en[d] !== 1'b1) begin
            total++; bad++;
            $display("FAIL out_timeout dut%0d: got no sum_out_en, expected within 300 cycles", d);
        end
    endtask

    task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          input logic [31:0] es, input logic ec, input logic eo, input string nm);
        bit ok;
        int cyc;
        out_rdy[d] = 1'b1;
        send(d, av, bv, sv, ok);
        wait_out(d, cyc);
        total++;
        if (out[d] !== es) begin
            bad++; $display("FAIL %s_sum dut%0d: got %h, expected %h", nm, d, out[d], es);
        end
        total++;
        if (cy[d] !== ec) begin
            bad++; $display("FAIL %s_carry dut%0d: got %b, expected %b", nm, d, cy[d], ec);
        end
        total++;
        if (ov[d] !== eo) begin
            bad++; $display("FAIL %s_ovf dut%0d: got %b, expected %b", nm, d, ov[d], eo);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        bit ok;
        int cyc;
        arst = 1'b0;
        a[0] = 32'hDEAD_BEEF; b[0] = 32'h1234_5678; sub[0] = 1'b0; en[0] = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_en[0] !== 1'b0) begin bad++; $display("FAIL rst_out_en: got %b, expected 0", out_en[0]); end
        total++;
        if (out[0] !== 32'h0) begin bad++; $display("FAIL rst_sum_out: got %h, expected 0", out[0]); end
        total++;
        if (cy[0] !== 1'b0) begin bad++; $display("FAIL rst_carry: got %b, expected 0", cy[0]); end
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b, expected 0", ov[0]); end
        total++;
        if (in_rdy[0] !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b, expected 1", in_rdy[0]); end
        en[0] = 1'b0;
        arst = 1'b1;
        @(negedge clk);
        out_rdy[0] = 1'b1;
        send(0, 32'd5, 32'd3, 1'b0, ok);
        wait_out(0, cyc);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL first_latency: got %0d, expected 4", cyc); end
        total++;
        if (out[0] !== 32'd8) begin bad++; $display("FAIL first_sum: got %h, expected 8", out[0]); end
        total++;
        if (cy[0] !== 1'b0 || ov[0] !== 1'b0) begin
            bad++; $display("FAIL first_flags: got c=%b o=%b, expected c=0 o=0", cy[0], ov[0]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_carry(input int d);
        run_op(d, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "allones_p1");
        run_op(d, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "ff_p1");
    endtask

    task automatic test_sub_ovf;
        run_op(0, 32'd3,         32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "3_m_5");
        run_op(0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "min_m_1");
        run_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "max_p_1");
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] exp_q[$];
        logic [31:0] obs;
        logic [31:0] first_res;
        int s, sent, got, first_c, last_c, exp_acc;
        bit rd, oe;
        s = stg(d);
        sent = 0;
        out_rdy[d] = 1'b0;
        for (int c = 0; c < s + 4; c++) begin
            if (sent < 8) begin
                a[d] = 32'hFFFF_FFF0 + sent; b[d] = 32'h0000_0010 + sent; sub[d] = 1'b0; en[d] = 1'b1;
            end else begin
                en[d] = 1'b0;
            end
            #1 rd = in_rdy[d];
            @(posedge clk);
            if (rd && en[d]) begin exp_q.push_back(a[d] + b[d]); sent++; end
            @(negedge clk);
        end
        exp_acc = (s < 8) ? s : 8;
        first_res = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
        total++;
        if (sent !== exp_acc) begin bad++; $display("FAIL bp_accepted dut%0d: got %0d, expected %0d", d, sent, exp_acc); end
        if (s < 8) begin
            total++;
            if (in_rdy[d] !== 1'b0) begin bad++; $display("FAIL bp_in_ready dut%0d: got %b, expected 0", d, in_rdy[d]); end
        end
        total++;
        if (out_en[d] !== 1'b1 || out[d] !== 32'h0000_0000) begin
            bad++; $display("FAIL bp_first dut%0d: got en=%b %h, expected en=1 00000000", d, out_en[d], out[d]);
        end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        total++;
        if (out_en[d] !== 1'b1 || out[d] !== first_res) begin
            bad++; $display("FAIL bp_hold dut%0d: got en=%b %h, expected en=1 %h", d, out_en[d], out[d], first_res);
        end
        out_rdy[d] = 1'b1;
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 200 && got < 8; c++) begin
            if (sent < 8) begin
                a[d] = 32'hFFFF_FFF0 + sent; b[d] = 32'h0000_0010 + sent; en[d] = 1'b1;
            end else begin
                en[d] = 1'b0;
            end
            #1 rd = in_rdy[d]; oe = out_en[d]; obs = out[d];
            @(posedge clk);
            if (rd && en[d]) begin exp_q.push_back(a[d] + b[d]); sent++; end
            if (oe) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra dut%0d: got %h, expected no output", d, obs);
                end else if (obs !== exp_q[0]) begin
                    bad++; $display("FAIL bp_order dut%0d: got %h, expected %h", d, obs, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            @(negedge clk);
        end
        en[d] = 1'b0;
        total++;
        if (got !== 8) begin bad++; $display("FAIL bp_count dut%0d: got %0d, expected 8", d, got); end
        total++;
        if (last_c - first_c !== 7) begin
            bad++; $display("FAIL bp_rate dut%0d: got span %0d, expected 7", d, last_c - first_c);
        end
    endtask

    task automatic test_bubble;
        logic [31:0] exp_q[$];
        logic [31:0] obs;
        bit ok, rd, oe;
        int got;
        out_rdy[0] = 1'b0;
        send(0, 32'd1, 32'd1, 1'b0, ok);
        exp_q.push_back(32'd2);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        for (int i = 0; i < 3; i++) begin
            a[0] = 32'd10 * (i + 2); b[0] = i; sub[0] = 1'b0; en[0] = 1'b1;
            #1 rd = in_rdy[0];
            total++;
            if (rd !== 1'b1) begin bad++; $display("FAIL bubble_accept%0d: got ready=%b, expected 1", i, rd); end
            @(posedge clk);
            if (rd) exp_q.push_back(32'd10 * (i + 2) + i);
            @(negedge clk);
        end
        a[0] = 32'd100; b[0] = 32'd7; en[0] = 1'b1;
        #1 rd = in_rdy[0];
        total++;
        if (rd !== 1'b0) begin bad++; $display("FAIL bubble_full: got ready=%b, expected 0", rd); end
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #1 rd = in_rdy[0];
        total++;
        if (rd !== 1'b0) begin bad++; $display("FAIL bubble_still_full: got ready=%b, expected 0", rd); end
        out_rdy[0] = 1'b1;
        #1 rd = in_rdy[0]; oe = out_en[0]; obs = out[0];
        total++;
        if (rd !== 1'b1) begin bad++; $display("FAIL bubble_passthru: got ready=%b, expected 1", rd); end
        total++;
        if (oe !== 1'b1 || obs !== 32'd2) begin
            bad++; $display("FAIL bubble_out0: got en=%b %h, expected en=1 00000002", oe, obs);
        end
        @(posedge clk);
        if (rd) exp_q.push_back(32'd107);
        void'(exp_q.pop_front());
        @(negedge clk);
        en[0] = 1'b0;
        got = 0;
        for (int c = 0; c < 50 && got < 4; c++) begin
            #1 oe = out_en[0]; obs = out[0];
            if (oe) begin
                total++;
                if (exp_q.size() == 0 || obs !== exp_q[0]) begin
                    bad++; $display("FAIL bubble_order%0d: got %h, expected %h", got, obs,
                                    (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (got !== 4) begin bad++; $display("FAIL bubble_drain: got %0d, expected 4", got); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int cyc, seen;
        out_rdy[0] = 1'b0;
        send(0, 32'h0000_1000, 32'h1, 1'b0, ok);
        send(0, 32'h0000_2000, 32'h2, 1'b0, ok);
        send(0, 32'h0000_3000, 32'h3, 1'b0, ok);
        wait_out(0, cyc);
        #2 arst = 1'b0;
        #1;
        total++;
        if (out_en[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_out_en: got %b, expected 0", out_en[0]); end
        total++;
        if (in_rdy[0] !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b, expected 1", in_rdy[0]); end
        @(negedge clk);
        arst = 1'b1;
        out_rdy[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1 if (out_en[0] === 1'b1) seen++;
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL mid_rst_ghost: got %0d outputs, expected 0", seen); end
        run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        arst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            a[d] = '0; b[d] = '0; sub[d] = 1'b0; en[d] = 1'b0; out_rdy[d] = 1'b1;
        end
        @(negedge clk);
        test_reset();
        test_carry(0);
        test_sub_ovf();
        test_back_to_back(0);
        test_bubble();
        test_reset_mid();
        test_carry(1);
        test_back_to_back(1);
        test_carry(2);
        test_back_to_back(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
